microseq_datapath: RTL and testbench
====================================

# microseq_datapath

Registered datapath of the microprogram sequencer. It sits directly downstream of the instruction decoder and consumes its control bundle every cycle. It holds the program counter (PC), the R register, a LIFO return stack and the output address register, and presents the next microaddress on `y`. All state updates in one clock cycle.

## Interface
Parameters:
- `AW`, 8: address/data width.
- `DEPTH`, 4: stack entries, must be at least 2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `d_in` in AW: external data/branch operand D.
- `sync_clr` in 1: synchronous clear, wired to the decoder `rst`.
- `cen` in 1: ALU add enable.
- `inc` in 1: PC increment.
- `pc_mux_sel` in 1: PC source, 1 = PC, 0 = ALU.
- `rsel` in 1: R source, 1 = ALU, 0 = D.
- `rce` in 1: R load enable.
- `a_mux_sel` in 2: A operand select.
- `b_mux_sel` in 2: B operand select.
- `push` in 1: stack push request.
- `pop` in 1: stack pop request.
- `stack_we` in 1: stack write qualifier.
- `stack_re` in 1: stack read qualifier.
- `src_sel` in 1: push data, 0 = PC+1, 1 = R.
- `out_ce` in 1: output register load.
- `oen` in 1: output enable, active high.
- `y` out AW: registered microaddress.
- `y_oe` out 1: equals `oen`, combinational.
- `pc_q` out AW: PC.
- `r_q` out AW: R.
- `sp` out clog2(DEPTH+1): stack occupancy.
- `full` out 1: sp == DEPTH.
- `empty` out 1: sp == 0.
- `ovf` out 1: sticky overflow flag.
- `unf` out 1: sticky underflow flag.

## Operation
- A mux: 00 R, 01 D, 10 zero, 11 stack top (zero when empty).
- B mux: 00 PC, 01 D, 10 zero, 11 D.
- ALU: `alu = cen ? (A+B) mod 2^AW : A|B`. No carry out.
- PC: `pc <= (pc_mux_sel ? pc : alu) + inc`, wrapping modulo 2^AW.
- R: `r <= rsel ? alu : d_in` when `rce`, otherwise hold.
- Output: `y <= alu` when `out_ce`, otherwise hold.
- Effective push is `push & stack_we`. Effective pop is `pop & stack_re`. Either control without its qualifier has no effect.
- Push, not full: write `src_sel ? r : pc+1` at index sp, then sp+1.
- Push when full: no write, sp holds, `ovf` sets.
- Pop, not empty: sp-1. Pop when empty: sp holds, `unf` sets.
- Push and pop together, not empty: the top entry is overwritten, sp holds.
- Push and pop together when empty: behaves as a plain push.
- `ovf` and `unf` stay set until `rst_n` or `sync_clr`.
- `sync_clr` has highest priority. It zeroes pc, r, y, sp, ovf and unf. Stack contents are don't-care.
- Decoder disable bundle (pc_mux_sel=1, inc=0, all enables 0): every register holds.

## Timing
- Async reset: pc, r, y, sp, ovf, unf = 0. Hence full=0, empty=1, y=0. `y_oe` tracks `oen` even during reset.
- Controls and `d_in` are sampled at the rising edge. Results appear one cycle later.
- Stack top and the ALU are combinational within the cycle. A pop and a use of the top (a_mux=11) in the same cycle use the pre-pop top.
- Reset deassertion mid-sequence: the first edge with `rst_n` high applies that cycle's controls normally.
- PC wrap: pc=2^AW-1 with inc gives 0, with no flag.

## Structure
- `microseq_pkg` holds the AMUX_R/D/ZERO/TOP and BMUX_PC/D/ZERO/D2 encodings and the ALU mode constants.
- Sub-module `microseq_stack` contains the LIFO storage, sp, full/empty and ovf/unf. Its ports are push_en, pop_en, wdata and top.
- The top level holds the muxes, ALU, PC, R and y.

## Test plan
AW=8, DEPTH=4.
- Reset, then idle bundle for 5 cycles -> pc=0, r=0, y=0, empty=1, full=0.
- pc_mux_sel=1, inc=1 for 3 cycles, then a=10, b=00, cen=0, rsel=1, rce=1, out_ce=1 -> r=3, y=3, pc=4.
- r=0x10, d_in=0x05, a=00, b=11, cen=1, rce=1, rsel=1 -> r=0x15. With pc_mux_sel=0 the same cycle -> pc=0x15.
- At pc=7: push, stack_we, src_sel=0 -> top=8, sp=1. Then a=11, b=10, cen=1, pc_mux_sel=0, pop, stack_re -> pc=8, sp=0.
- 5 qualified pushes -> sp=4, full=1, ovf=1, entries unchanged. 5 pops -> sp=0, unf=1. Then sync_clr -> ovf=0, unf=0.
- Push and pop together at sp=2 -> sp=2, top replaced. Assert rst_n=0 mid-push -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogram sequencer datapath: operand mux
// selects and ALU mode values.
package microseq_pkg;

  localparam logic [1:0] AMUX_R    = 2'b00;
  localparam logic [1:0] AMUX_D    = 2'b01;
  localparam logic [1:0] AMUX_ZERO = 2'b10;
  localparam logic [1:0] AMUX_TOP  = 2'b11;

  localparam logic [1:0] BMUX_PC   = 2'b00;
  localparam logic [1:0] BMUX_D    = 2'b01;
  localparam logic [1:0] BMUX_ZERO = 2'b10;
  localparam logic [1:0] BMUX_D2   = 2'b11;

  // Value of cen selecting each ALU operation.
  localparam logic ALU_OR  = 1'b0;
  localparam logic ALU_ADD = 1'b1;

endpackage

// File: rtl/microseq_stack.sv
// LIFO return stack with occupancy count, full/empty and sticky
// overflow/underflow flags; top is combinational and reads zero when empty.
module microseq_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync_clr,
  input  logic          push_en,
  input  logic          pop_en,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic [SPW-1:0] sp,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] top_idx;
  logic           do_replace;
  logic           do_push;
  logic           do_pop;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - SPW'(1);
  assign top     = empty ? '0 : mem[top_idx[IW-1:0]];

  // Push+pop on a non-empty stack rewrites the top; on an empty stack it
  // degenerates to a plain push.
  assign do_replace = push_en & pop_en & ~empty;
  assign do_push    = push_en & ~do_replace;
  assign do_pop     = pop_en & ~push_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (sync_clr) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (do_push) begin
      if (full) ovf <= 1'b1;
      else      sp  <= sp + SPW'(1);
    end else if (do_pop) begin
      if (empty) unf <= 1'b1;
      else       sp  <= sp - SPW'(1);
    end
  end

  // Storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (rst_n && !sync_clr) begin
      if (do_replace)
        mem[top_idx[IW-1:0]] <= wdata;
      else if (do_push && !full)
        mem[sp[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/microseq_datapath.sv
// Registered datapath of the microprogram sequencer: operand muxes, ALU,
// PC, R, output address register and the return stack.
module microseq_datapath
  import microseq_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              d_in,
  input  logic                       sync_clr,
  input  logic                       cen,
  input  logic                       inc,
  input  logic                       pc_mux_sel,
  input  logic                       rsel,
  input  logic                       rce,
  input  logic [1:0]                 a_mux_sel,
  input  logic [1:0]                 b_mux_sel,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       stack_we,
  input  logic                       stack_re,
  input  logic                       src_sel,
  input  logic                       out_ce,
  input  logic                       oen,
  output logic [AW-1:0]              y,
  output logic                       y_oe,
  output logic [AW-1:0]              pc_q,
  output logic [AW-1:0]              r_q,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  logic [AW-1:0] a_op;
  logic [AW-1:0] b_op;
  logic [AW-1:0] alu;
  logic [AW-1:0] top;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] push_data;

  always_comb begin
    a_op = '0;
    unique case (a_mux_sel)
      AMUX_R:    a_op = r_q;
      AMUX_D:    a_op = d_in;
      AMUX_ZERO: a_op = '0;
      AMUX_TOP:  a_op = top;
      default:   a_op = '0;
    endcase
  end

  always_comb begin
    b_op = '0;
    unique case (b_mux_sel)
      BMUX_PC:   b_op = pc_q;
      BMUX_D:    b_op = d_in;
      BMUX_ZERO: b_op = '0;
      BMUX_D2:   b_op = d_in;
      default:   b_op = '0;
    endcase
  end

  assign alu       = (cen == ALU_ADD) ? (a_op + b_op) : (a_op | b_op);
  assign pc_inc    = pc_q + AW'(1);
  assign pc_next   = (pc_mux_sel ? pc_q : alu) + AW'(inc);
  assign push_data = src_sel ? r_q : pc_inc;
  assign y_oe      = oen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      r_q  <= '0;
      y    <= '0;
    end else if (sync_clr) begin
      pc_q <= '0;
      r_q  <= '0;
      y    <= '0;
    end else begin
      pc_q <= pc_next;
      if (rce)    r_q <= rsel ? alu : d_in;
      if (out_ce) y   <= alu;
    end
  end

  microseq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .push_en  (push & stack_we),
    .pop_en   (pop & stack_re),
    .wdata    (push_data),
    .top      (top),
    .sp       (sp),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf)
  );

endmodule

// File: tb/tb_microseq_datapath.sv
// Directed bench for microseq_datapath (AW=8, DEPTH=4) with hand-computed
// expected values checked by immediate assertions.
module tb_microseq_datapath;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] d_in;
  logic          sync_clr, cen, inc, pc_mux_sel, rsel, rce;
  logic [1:0]    a_mux_sel, b_mux_sel;
  logic          push, pop, stack_we, stack_re, src_sel, out_ce, oen;
  logic [AW-1:0] y, pc_q, r_q;
  logic          y_oe, full, empty, ovf, unf;
  logic [2:0]    sp;

  int n_assert = 0;
  int n_fail   = 0;

  microseq_datapath #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .sync_clr(sync_clr), .cen(cen),
    .inc(inc), .pc_mux_sel(pc_mux_sel), .rsel(rsel), .rce(rce),
    .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel), .push(push), .pop(pop),
    .stack_we(stack_we), .stack_re(stack_re), .src_sel(src_sel),
    .out_ce(out_ce), .oen(oen), .y(y), .y_oe(y_oe), .pc_q(pc_q), .r_q(r_q),
    .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Disable bundle: every register holds.
  task automatic idle();
    sync_clr = 0; cen = 0; inc = 0; pc_mux_sel = 1; rsel = 0; rce = 0;
    a_mux_sel = 2'b00; b_mux_sel = 2'b00; push = 0; pop = 0;
    stack_we = 0; stack_re = 0; src_sel = 0; out_ce = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] pop_exp [5];

  initial begin
    pop_exp[0] = 8'h22; pop_exp[1] = 8'h21; pop_exp[2] = 8'h20;
    pop_exp[3] = 8'h15; pop_exp[4] = 8'h00;
    idle();
    d_in = '0; oen = 1; rst_n = 0;
    #12;
    chk("reset_pc", pc_q, 0);
    chk("reset_empty", empty, 1);
    chk("reset_y_oe", y_oe, 1);
    oen = 0; #1;
    chk("reset_y_oe_low", y_oe, 0);
    oen = 1;
    @(negedge clk); rst_n = 1;

    // idle 5 cycles
    for (int i = 0; i < 5; i++) step();
    chk("idle_pc", pc_q, 0);
    chk("idle_r", r_q, 0);
    chk("idle_y", y, 0);
    chk("idle_empty", empty, 1);
    chk("idle_full", full, 0);

    // count PC up, then R and y load PC via OR with zero
    inc = 1;
    for (int i = 0; i < 3; i++) step();
    chk("inc_pc", pc_q, 3);
    a_mux_sel = 2'b10; b_mux_sel = 2'b00; cen = 0; rsel = 1; rce = 1; out_ce = 1;
    step();
    chk("or_r", r_q, 3);
    chk("or_y", y, 3);
    chk("or_pc", pc_q, 4);

    // R = D, then R = R + D with PC from the ALU
    idle(); rce = 1; rsel = 0; d_in = 8'h10;
    step();
    chk("load_r", r_q, 8'h10);
    idle(); d_in = 8'h05; a_mux_sel = 2'b00; b_mux_sel = 2'b11; cen = 1;
    rce = 1; rsel = 1; pc_mux_sel = 0;
    step();
    chk("add_r", r_q, 8'h15);
    chk("add_pc", pc_q, 8'h15);
    chk("y_hold", y, 3);

    // PC = 7 via D + 0
    idle(); d_in = 8'h07; a_mux_sel = 2'b01; b_mux_sel = 2'b10; cen = 1; pc_mux_sel = 0;
    step();
    chk("load_pc7", pc_q, 7);
    idle(); push = 1;
    step();
    chk("unqual_push_sp", sp, 0);
    idle(); push = 1; stack_we = 1; src_sel = 0;
    step();
    chk("push_sp", sp, 1);
    chk("push_empty", empty, 0);
    idle(); pop = 1;
    step();
    chk("unqual_pop_sp", sp, 1);
    // return: PC = pre-pop top + 0
    idle(); a_mux_sel = 2'b11; b_mux_sel = 2'b10; cen = 1; pc_mux_sel = 0;
    pop = 1; stack_re = 1; out_ce = 1;
    step();
    chk("ret_pc", pc_q, 8);
    chk("ret_y", y, 8);
    chk("ret_sp", sp, 0);

    // 5 pushes of R while R is reloaded from D
    for (int i = 0; i < 5; i++) begin
      idle(); d_in = 8'h20 + 8'(i); rce = 1; rsel = 0;
      push = 1; stack_we = 1; src_sel = 1;
      step();
    end
    chk("fill_sp", sp, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 1);
    chk("fill_r", r_q, 8'h24);
    for (int i = 0; i < 5; i++) begin
      idle(); a_mux_sel = 2'b11; b_mux_sel = 2'b10; out_ce = 1;
      pop = 1; stack_re = 1;
      step();
      chk($sformatf("pop%0d_y", i), y, pop_exp[i]);
    end
    chk("drain_sp", sp, 0);
    chk("drain_unf", unf, 1);
    chk("drain_ovf_sticky", ovf, 1);
    idle(); sync_clr = 1; inc = 1; push = 1; stack_we = 1; rce = 1; d_in = 8'hAA;
    step();
    chk("clr_ovf", ovf, 0);
    chk("clr_unf", unf, 0);
    chk("clr_pc", pc_q, 0);
    chk("clr_r", r_q, 0);
    chk("clr_y", y, 0);
    chk("clr_sp", sp, 0);

    // two pushes of PC+1, then push+pop replaces the top with R
    idle(); inc = 1; push = 1; stack_we = 1; rce = 1; d_in = 8'h55;
    step();
    idle(); inc = 1; push = 1; stack_we = 1;
    step();
    chk("two_sp", sp, 2);
    chk("two_pc", pc_q, 2);
    idle(); push = 1; pop = 1; stack_we = 1; stack_re = 1; src_sel = 1;
    step();
    chk("swap_sp", sp, 2);
    idle(); a_mux_sel = 2'b11; b_mux_sel = 2'b10; out_ce = 1;
    step();
    chk("swap_top", y, 8'h55);
    idle(); a_mux_sel = 2'b11; b_mux_sel = 2'b10; out_ce = 1; pop = 1; stack_re = 1;
    step();
    idle(); a_mux_sel = 2'b11; b_mux_sel = 2'b10; out_ce = 1;
    step();
    chk("below_top", y, 8'h01);

    // PC wrap
    idle(); d_in = 8'hFF; a_mux_sel = 2'b01; b_mux_sel = 2'b10; cen = 1; pc_mux_sel = 0;
    step();
    chk("pc_ff", pc_q, 8'hFF);
    idle(); inc = 1;
    step();
    chk("pc_wrap", pc_q, 0);

    // async reset in the middle of a push
    idle(); inc = 1; push = 1; stack_we = 1; oen = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_pc", pc_q, 0);
    chk("mid_rst_r", r_q, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_sp", sp, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_y_oe", y_oe, 0);
    @(negedge clk); rst_n = 1;
    step();
    chk("post_rst_sp", sp, 1);
    chk("post_rst_pc", pc_q, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
